ctrl_store_loader: RTL

//  Writer side of the 512x19 instruction-decode control store: takes a byte stream over a

---
 rtl/ctrl_store_loader.sv | 94 +++++++++
 1 files changed

// File: rtl/ctrl_store_loader.sv
// Control-store writer: packs a byte stream into control words, writes them to
// addresses 0..DEPTH-1 and then verifies an XOR checksum trailer.
module ctrl_store_loader #(
  parameter int unsigned DEPTH  = 512,
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned WORD_W = 19
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [7:0]        i_byte,
  input  logic              i_byte_vld,
  output logic              o_byte_rdy,
  output logic              o_we,
  output logic [ADDR_W-1:0] o_waddr,
  output logic [WORD_W-1:0] o_wdata,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  localparam int unsigned HI_W = WORD_W - 16;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_CHECK = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_ERR   = 3'd4;

  logic [2:0]        state;
  logic [ADDR_W-1:0] addr;
  logic [1:0]        bidx;
  logic [HI_W-1:0]   hi;
  logic [7:0]        mid;
  logic [WORD_W-1:0] csum;
  logic [WORD_W-1:0] word;
  logic              accept;

  assign o_byte_rdy = (state == S_LOAD) || (state == S_CHECK);
  assign o_busy     = o_byte_rdy;
  assign o_done     = (state == S_DONE);
  assign o_err      = (state == S_ERR);
  assign accept     = i_byte_vld && o_byte_rdy;
  assign word       = {hi, mid, i_byte};

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state   <= S_IDLE;
      addr    <= '0;
      bidx    <= '0;
      hi      <= '0;
      mid     <= '0;
      csum    <= '0;
      o_we    <= 1'b0;
      o_waddr <= '0;
      o_wdata <= '0;
    end else begin
      o_we <= 1'b0;
      // Restart wins over any byte accepted this cycle; that byte is discarded.
      if (i_start) begin
        state <= S_LOAD;
        addr  <= '0;
        bidx  <= '0;
        csum  <= '0;
      end else if (accept) begin
        case (bidx)
          2'd0: begin
            hi <= i_byte[HI_W-1:0];
            if (state == S_LOAD && i_byte[7:HI_W] != '0) state <= S_ERR;
            else                                          bidx  <= 2'd1;
          end
          2'd1: begin
            mid  <= i_byte;
            bidx <= 2'd2;
          end
          default: begin
            bidx <= 2'd0;
            if (state == S_LOAD) begin
              o_we    <= 1'b1;
              o_waddr <= addr;
              o_wdata <= word;
              csum    <= csum ^ word;
              if (addr == ADDR_W'(DEPTH - 1)) state <= S_CHECK;
              else                             addr  <= addr + 1'b1;
            end else begin
              state <= (word == csum) ? S_DONE : S_ERR;
            end
          end
        endcase
      end
    end
  end

endmodule
